// File: rtl/rss_disp.sv
// rtl/rss_disp.sv - credit-gated dispatch of up to three lanes per cycle into a 32-entry reservation station
// Optional lane packing to lowest slots: define RSS_DISP_COMPACT_EN.
module rss_disp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       rst_thread,
  input  logic       inValid0,
  input  logic       inValid1,
  input  logic       inValid2,
  input  logic       inANeeded0,
  input  logic       inANeeded1,
  input  logic       inANeeded2,
  input  logic       inBNeeded0,
  input  logic       inBNeeded1,
  input  logic       inBNeeded2,
  input  logic [4:0] inPort0,
  input  logic [4:0] inPort1,
  input  logic [4:0] inPort2,
  input  logic       inThread,
  input  logic       portIssue0,
  input  logic       portIssue1,
  input  logic       portIssue2,
  input  logic       portIssue3,
  output logic       inReady,
  output logic       newRsSelect0,
  output logic       newRsSelect1,
  output logic       newRsSelect2,
  output logic       newANeeded0,
  output logic       newANeeded1,
  output logic       newANeeded2,
  output logic       newBNeeded0,
  output logic       newBNeeded1,
  output logic       newBNeeded2,
  output logic [4:0] newPort0,
  output logic [4:0] newPort1,
  output logic [4:0] newPort2,
  output logic       new_thread,
  output logic [5:0] credits,
  output logic       drained
);

  localparam logic [5:0] RS_DEPTH = 6'd32;

  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [2:0] lane_v, lane_a, lane_b;
  logic [4:0] lane_p [3];
  logic [2:0] slot_v, slot_a, slot_b;
  logic [4:0] slot_p [3];
  logic [2:0] sel_q, a_q, b_q;
  logic [4:0] port_q [3];
  logic       thr_q;
  logic [1:0] nv;
  logic [2:0] ni;
  logic       accept;
  logic [6:0] cred_sum;
  logic [5:0] cred_nxt;

  assign lane_v = {inValid2, inValid1, inValid0};
  assign lane_a = {inANeeded2, inANeeded1, inANeeded0};
  assign lane_b = {inBNeeded2, inBNeeded1, inBNeeded0};
  assign lane_p[0] = inPort0;
  assign lane_p[1] = inPort1;
  assign lane_p[2] = inPort2;

  assign nv = {1'b0, inValid0} + {1'b0, inValid1} + {1'b0, inValid2};
  assign ni = {2'b0, portIssue0} + {2'b0, portIssue1} + {2'b0, portIssue2} + {2'b0, portIssue3};

  // Registered credits only, so an issue return cannot open the gate in its own cycle.
  assign inReady = (state == RUN) && !stall && (credits >= {4'b0, nv});
  assign accept  = inReady && (nv != 2'd0);

`ifdef RSS_DISP_COMPACT_EN
  logic [1:0] k;
  always_comb begin
    slot_v = '0;
    slot_a = '0;
    slot_b = '0;
    slot_p = '{default: '0};
    k      = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (lane_v[i]) begin
        slot_v[k] = 1'b1;
        slot_a[k] = lane_a[i];
        slot_b[k] = lane_b[i];
        slot_p[k] = lane_p[i];
        k         = k + 2'd1;
      end
    end
  end
`else
  assign slot_v = lane_v;
  assign slot_a = lane_a;
  assign slot_b = lane_b;
  assign slot_p = lane_p;
`endif

  // Accept never exceeds credits, so the subtraction cannot wrap; only spurious issues can overshoot.
  always_comb begin
    cred_sum = {1'b0, credits} - (accept ? {5'b0, nv} : 7'd0) + {4'b0, ni};
    cred_nxt = (cred_sum > {1'b0, RS_DEPTH}) ? RS_DEPTH : cred_sum[5:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (rst_thread) state_nxt = DRAIN;
      DRAIN:   if ((credits == RS_DEPTH) && !rst_thread) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      credits <= RS_DEPTH;
      sel_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      port_q  <= '{default: '0};
      thr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      credits <= cred_nxt;
      if (!stall) begin
        if (accept) begin
          sel_q  <= slot_v;
          a_q    <= slot_a;
          b_q    <= slot_b;
          port_q <= slot_p;
          thr_q  <= inThread;
        end else begin
          sel_q  <= '0;
        end
      end
    end
  end

  assign drained      = (state == DRAIN) && (credits == RS_DEPTH);
  assign newRsSelect0 = sel_q[0];
  assign newRsSelect1 = sel_q[1];
  assign newRsSelect2 = sel_q[2];
  assign newANeeded0  = a_q[0];
  assign newANeeded1  = a_q[1];
  assign newANeeded2  = a_q[2];
  assign newBNeeded0  = b_q[0];
  assign newBNeeded1  = b_q[1];
  assign newBNeeded2  = b_q[2];
  assign newPort0     = port_q[0];
  assign newPort1     = port_q[1];
  assign newPort2     = port_q[2];
  assign new_thread   = thr_q;

endmodule

// File: tb/tb_rss_disp.sv
// tb/tb_rss_disp.sv - scoreboard bench for rss_disp (honours RSS_DISP_COMPACT_EN)
module tb_rss_disp;

  logic       clk = 1'b0;
  logic       rst_n, stall, rst_thread;
  logic       inValid0, inValid1, inValid2;
  logic       inANeeded0, inANeeded1, inANeeded2;
  logic       inBNeeded0, inBNeeded1, inBNeeded2;
  logic [4:0] inPort0, inPort1, inPort2;
  logic       inThread;
  logic       portIssue0, portIssue1, portIssue2, portIssue3;
  logic       inReady;
  logic       newRsSelect0, newRsSelect1, newRsSelect2;
  logic       newANeeded0, newANeeded1, newANeeded2;
  logic       newBNeeded0, newBNeeded1, newBNeeded2;
  logic [4:0] newPort0, newPort1, newPort2;
  logic       new_thread;
  logic [5:0] credits;
  logic       drained;

  rss_disp dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .rst_thread(rst_thread),
    .inValid0(inValid0), .inValid1(inValid1), .inValid2(inValid2),
    .inANeeded0(inANeeded0), .inANeeded1(inANeeded1), .inANeeded2(inANeeded2),
    .inBNeeded0(inBNeeded0), .inBNeeded1(inBNeeded1), .inBNeeded2(inBNeeded2),
    .inPort0(inPort0), .inPort1(inPort1), .inPort2(inPort2), .inThread(inThread),
    .portIssue0(portIssue0), .portIssue1(portIssue1), .portIssue2(portIssue2), .portIssue3(portIssue3),
    .inReady(inReady),
    .newRsSelect0(newRsSelect0), .newRsSelect1(newRsSelect1), .newRsSelect2(newRsSelect2),
    .newANeeded0(newANeeded0), .newANeeded1(newANeeded1), .newANeeded2(newANeeded2),
    .newBNeeded0(newBNeeded0), .newBNeeded1(newBNeeded1), .newBNeeded2(newBNeeded2),
    .newPort0(newPort0), .newPort1(newPort1), .newPort2(newPort2),
    .new_thread(new_thread), .credits(credits), .drained(drained)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  sel;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [14:0] p;
    logic        thr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   m_cred;
  bit   m_drain;
  exp_t m_out;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cred  = 32;
    m_drain = 1'b0;
    m_out   = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    logic [4:0] dp [3];
    logic [2:0] da, db;
    dp[0] = newPort0; dp[1] = newPort1; dp[2] = newPort2;
    da = {newANeeded2, newANeeded1, newANeeded0};
    db = {newBNeeded2, newBNeeded1, newBNeeded0};
    chk("credits", int'(credits), m_cred);
    chk("sel", int'({newRsSelect2, newRsSelect1, newRsSelect0}), int'(m_out.sel));
    chk("thread", int'(new_thread), int'(m_out.thr));
    for (int s = 0; s < 3; s++) begin
      if (m_out.sel[s]) begin
        chk("port", int'(dp[s]), int'(m_out.p[s*5 +: 5]));
        chk("a_need", int'(da[s]), int'(m_out.a[s]));
        chk("b_need", int'(db[s]), int'(m_out.b[s]));
      end
    end
  endtask

  // One cycle: drive at posedge+1, check combinational outputs mid-cycle, registered ones at next posedge+1.
  task automatic step(input logic [2:0] v, input logic [2:0] an, input logic [2:0] bn,
                      input logic [4:0] p0, input logic [4:0] p1, input logic [4:0] p2,
                      input logic th, input logic [3:0] iss, input logic st, input logic rt);
    int   nv, ni, slot, nxt;
    bit   rdy, acc, drain_n;
    exp_t e;
    logic [4:0] pl [3];
    {inValid2, inValid1, inValid0}       = v;
    {inANeeded2, inANeeded1, inANeeded0} = an;
    {inBNeeded2, inBNeeded1, inBNeeded0} = bn;
    inPort0 = p0; inPort1 = p1; inPort2 = p2;
    inThread = th;
    {portIssue3, portIssue2, portIssue1, portIssue0} = iss;
    stall = st;
    rst_thread = rt;
    #3;
    nv  = $countones(v);
    ni  = $countones(iss);
    rdy = !m_drain && !st && (m_cred >= nv);
    chk("in_ready", int'(inReady), int'(rdy));
    chk("drained", int'(drained), int'(m_drain && m_cred == 32));
    acc = rdy && (nv != 0);
    if (acc) begin
      pl[0] = p0; pl[1] = p1; pl[2] = p2;
      e = '0;
      e.thr = th;
      slot = 0;
      for (int l = 0; l < 3; l++) begin
        if (v[l]) begin
`ifdef RSS_DISP_COMPACT_EN
          e.sel[slot] = 1'b1; e.a[slot] = an[l]; e.b[slot] = bn[l]; e.p[slot*5 +: 5] = pl[l];
`else
          e.sel[l] = 1'b1; e.a[l] = an[l]; e.b[l] = bn[l]; e.p[l*5 +: 5] = pl[l];
`endif
          slot++;
        end
      end
      exp_q.push_back(e);
    end
    nxt = m_cred - (acc ? nv : 0) + ni;
    if (nxt > 32) nxt = 32;
    drain_n = m_drain ? !(m_cred == 32 && !rt) : rt;
    @(posedge clk);
    #1;
    m_cred  = nxt;
    m_drain = drain_n;
    if (acc) begin
      if (exp_q.size() == 0) chk("queue_empty", 1, 0);
      else m_out = exp_q.pop_front();
    end else if (!st) begin
      m_out.sel = 3'b000;
    end
    check_outputs();
  endtask

  task automatic idle(input logic [3:0] iss, input logic st, input logic rt);
    step(3'b000, 3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 1'b0, iss, st, rt);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; rst_thread = 1'b0;
    {inValid2, inValid1, inValid0} = '0;
    {inANeeded2, inANeeded1, inANeeded0} = '0;
    {inBNeeded2, inBNeeded1, inBNeeded0} = '0;
    inPort0 = '0; inPort1 = '0; inPort2 = '0; inThread = 1'b0;
    {portIssue3, portIssue2, portIssue1, portIssue0} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_credits", int'(credits), 32);
    chk("rst_sel", int'({newRsSelect2, newRsSelect1, newRsSelect0}), 0);
    chk("rst_ports", int'({newPort2, newPort1, newPort0}), 0);
    chk("rst_ab", int'({newANeeded2, newANeeded1, newANeeded0, newBNeeded2, newBNeeded1, newBNeeded0}), 0);
    chk("rst_thread", int'(new_thread), 0);
    chk("rst_drained", int'(drained), 0);
    chk("rst_ready", int'(inReady), 1);
    rst_n = 1'b1;

    // Full group straight out of reset.
    step(3'b111, 3'b101, 3'b011, 5'd5, 5'd9, 5'd17, 1'b1, 4'b0000, 1'b0, 1'b0);
    chk("cred_29", int'(credits), 29);

    // Starve credits down to 2, then show issue return is not visible until the next cycle.
    repeat (9) step(3'b111, 3'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom), 4'b0000, 1'b0, 1'b0);
    chk("cred_2", int'(credits), 2);
    step(3'b111, 3'b000, 3'b111, 5'd1, 5'd2, 5'd3, 1'b0, 4'b0001, 1'b0, 1'b0);
    chk("cred_3", int'(credits), 3);
    step(3'b111, 3'b010, 3'b100, 5'd4, 5'd6, 5'd8, 1'b0, 4'b0000, 1'b0, 1'b0);
    chk("cred_0", int'(credits), 0);
    repeat (5) idle(4'b1111, 1'b0, 1'b0);
    chk("cred_20", int'(credits), 20);
    step(3'b011, 3'b001, 3'b010, 5'd30, 5'd31, 5'd0, 1'b1, 4'b1111, 1'b0, 1'b0);
    chk("cred_22", int'(credits), 22);

    // Stall holds outputs and blocks accept; release with no valid yields a bubble.
    step(3'b111, 3'b110, 3'b001, 5'd1, 5'd2, 5'd3, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (3) step(3'b111, 3'b001, 3'b110, 5'd10, 5'd20, 5'd30, 1'b1, 4'b0000, 1'b1, 1'b0);
    idle(4'b0000, 1'b0, 1'b0);
    chk("bubble_sel", int'({newRsSelect2, newRsSelect1, newRsSelect0}), 0);

    // Thread reset arriving with an accept, then drain back to full.
    while (m_cred < 29) idle(4'b0001, 1'b0, 1'b0);
    step(3'b001, 3'b001, 3'b000, 5'd12, 5'd0, 5'd0, 1'b1, 4'b0000, 1'b0, 1'b1);
    chk("drain_cred_28", int'(credits), 28);
    step(3'b111, 3'b000, 3'b000, 5'd1, 5'd1, 5'd1, 1'b0, 4'b0000, 1'b0, 1'b0);
    repeat (4) idle(4'b0001, 1'b0, 1'b0);
    chk("drained_hi", int'(drained), 1);
    idle(4'b0000, 1'b0, 1'b0);
    chk("drained_lo", int'(drained), 0);
    chk("run_ready", int'(inReady), 1);

    // Spurious issue at full capacity clamps.
    idle(4'b1111, 1'b0, 1'b0);
    chk("clamp_32", int'(credits), 32);

    // Lanes 1 and 2 only.
    step(3'b110, 3'b010, 3'b100, 5'd7, 5'd11, 5'd13, 1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef RSS_DISP_COMPACT_EN
    chk("holes_sel", int'({newRsSelect2, newRsSelect1, newRsSelect0}), 3'b011);
`else
    chk("holes_sel", int'({newRsSelect2, newRsSelect1, newRsSelect0}), 3'b110);
`endif

    // Asynchronous reset mid-cycle discards the in-flight group.
    {inValid2, inValid1, inValid0} = 3'b111;
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_sel", int'({newRsSelect2, newRsSelect1, newRsSelect0}), 0);
    chk("async_thread", int'(new_thread), 0);
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    rst_n = 1'b1;
    step(3'b101, 3'b100, 3'b001, 5'd3, 5'd0, 5'd21, 1'b1, 4'b0000, 1'b0, 1'b0);

    // Random traffic against the model.
    repeat (300) begin
      step(3'($urandom), 3'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           1'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000,
           $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
